alu_b_output_unit: RTL and testbench

- Datapath stage directly downstream of the accumulator (A register) in the SAP-1 style machine.
- Holds the B register, which is loaded from the RAM data path.
- Forms A+B or A−B for write-back to A, and keeps registered carry/zero flags.
- Buffers OUT-instruction values (taken from A) in a 2-entry output queue with a valid/ready handshake to the display.
- Controlled by the sequencer's Lb, Su, Eu and Lo lines.

---
 rtl/sap_pkg.sv | 14 +
 rtl/out_fifo2.sv | 54 +++++
 rtl/alu_b_output_unit.sv | 71 +++++++
 tb/tb_alu_b_output_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared constants and types for the SAP-1 style datapath.
// Used by the ALU/B stage and its output queue.
package sap_pkg;

  localparam int DATA_W    = 4;
  localparam int ADDR_W    = 4;
  localparam int OUT_DEPTH = 2;

  typedef struct packed {
    logic carry;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/out_fifo2.sv
// Two-entry output queue with valid/ready drain and a sticky
// overflow bit for pushes that arrive while the queue is full.
module out_fifo2
  import sap_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int DEPTH = OUT_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_req,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  input  logic         ready,
  output logic         overflow
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         full;
  logic         pop;
  logic         push;

  assign full  = (count == 2'(DEPTH));
  assign valid = (count != 2'd0);
  assign pop   = valid && ready;
  // a pop in the same cycle frees the slot for the push
  assign push  = push_req && (!full || pop);
  assign dout  = valid ? mem[rd_ptr] : '0;

  // pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push) wr_ptr <= ~wr_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  // entry storage; contents are masked by valid so no reset needed
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_b_output_unit.sv
// B register, add/subtract ALU with registered flags, and the
// OUT-instruction queue feeding the display.
module alu_b_output_unit #(
  parameter int DATA_W    = sap_pkg::DATA_W,
  parameter int OUT_DEPTH = sap_pkg::OUT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] a_data,
  input  logic              Lb,
  input  logic              Su,
  input  logic              Eu,
  input  logic              Lo,
  output logic [DATA_W-1:0] alu_out,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
);

  import sap_pkg::*;

  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W:0]   sum;
  alu_flags_t        flags;

  // two's-complement subtract done at DATA_W+1 bits so that
  // B=0 still yields carry (no borrow)
  assign opnd = Su ? ~b_reg : b_reg;
  assign sum  = {1'b0, a_data} + {1'b0, opnd}
              + {{DATA_W{1'b0}}, Su};

  assign alu_out    = Eu ? sum[DATA_W-1:0] : '0;
  assign carry_flag = flags.carry;
  assign zero_flag  = flags.zero;

  // B register load from the RAM data path
  always_ff @(posedge clk) begin
    if (reset)   b_reg <= '0;
    else if (Lb) b_reg <= ram_data;
  end

  // flags capture the result whenever the ALU is enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else if (Eu) begin
      flags.carry <= sum[DATA_W];
      flags.zero  <= (sum[DATA_W-1:0] == '0);
    end
  end

  out_fifo2 #(
    .W     (DATA_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_req (Lo),
    .din      (a_data),
    .dout     (out_data),
    .valid    (out_valid),
    .ready    (out_ready),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_alu_b_output_unit.sv
// Self-checking bench for alu_b_output_unit: directed ALU tests
// plus a queue scoreboard for the output path.
module tb_alu_b_output_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ram_data;
  logic [3:0] a_data;
  logic       Lb, Su, Eu, Lo;
  logic [3:0] alu_out;
  logic       carry_flag, zero_flag;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q [$];
  logic       exp_ovf = 1'b0;

  always #5 clk = ~clk;

  alu_b_output_unit dut (
    .clk        (clk),
    .reset      (reset),
    .ram_data   (ram_data),
    .a_data     (a_data),
    .Lb         (Lb),
    .Su         (Su),
    .Eu         (Eu),
    .Lo         (Lo),
    .alu_out    (alu_out),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_b(input logic [3:0] v);
    Lb = 1'b1;
    ram_data = v;
    cyc();
    Lb = 1'b0;
  endtask

  // one queue cycle; scoreboard head compared before the edge
  task automatic fifo_cycle(input logic lo, input logic [3:0] a,
                            input logic rdy);
    logic [3:0] head;
    logic       pop;
    logic       push;
    Lo = lo;
    a_data = a;
    out_ready = rdy;
    @(negedge clk);
    head = (exp_q.size() != 0) ? exp_q[0] : 4'd0;
    checks++;
    if (out_valid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL out_valid got %b want %b",
               out_valid, exp_q.size() != 0);
    end
    checks++;
    if (out_data !== head) begin
      errors++;
      $display("FAIL out_data got %h want %h", out_data, head);
    end
    pop  = (exp_q.size() != 0) && rdy;
    push = lo && ((exp_q.size() < 2) || pop);
    if (lo && !push) exp_ovf = 1'b1;
    cyc();
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back(a);
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL overflow got %b want %b", overflow, exp_ovf);
    end
    Lo = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    checks++;
    if ({alu_out, carry_flag, zero_flag, out_valid,
         out_data, overflow} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 000",
               {alu_out, carry_flag, zero_flag, out_valid,
                out_data, overflow});
    end
    Eu = 1'b1;
    Su = 1'b0;
    a_data = 4'b0101;
    #1;
    checks++;
    if (alu_out !== 4'b0101) begin
      errors++;
      $display("FAIL reset_b got %b want 0101", alu_out);
    end
    cyc();
    Eu = 1'b0;
  endtask

  task automatic test_add();
    load_b(4'b0011);
    a_data = 4'b0101;
    Eu = 1'b1;
    Su = 1'b0;
    #1;
    checks++;
    if (alu_out !== 4'b1000) begin
      errors++;
      $display("FAIL add_out got %b want 1000", alu_out);
    end
    cyc();
    checks++;
    if ({carry_flag, zero_flag} !== 2'b00) begin
      errors++;
      $display("FAIL add_flags got %b want 00",
               {carry_flag, zero_flag});
    end
    Eu = 1'b0;
  endtask

  task automatic test_add_wrap();
    load_b(4'b0001);
    a_data = 4'b1111;
    Eu = 1'b1;
    Su = 1'b0;
    #1;
    checks++;
    if (alu_out !== 4'b0000) begin
      errors++;
      $display("FAIL wrap_out got %b want 0000", alu_out);
    end
    cyc();
    checks++;
    if ({carry_flag, zero_flag} !== 2'b11) begin
      errors++;
      $display("FAIL wrap_flags got %b want 11",
               {carry_flag, zero_flag});
    end
    Eu = 1'b0;
  endtask

  task automatic test_flag_hold();
    Eu = 1'b0;
    Su = 1'b1;
    a_data = 4'b0011;
    #1;
    checks++;
    if (alu_out !== 4'b0000) begin
      errors++;
      $display("FAIL disabled_out got %b want 0000", alu_out);
    end
    cyc();
    checks++;
    if ({carry_flag, zero_flag} !== 2'b11) begin
      errors++;
      $display("FAIL hold_flags got %b want 11",
               {carry_flag, zero_flag});
    end
    Su = 1'b0;
  endtask

  task automatic test_sub();
    load_b(4'b0011);
    a_data = 4'b0011;
    Su = 1'b1;
    Eu = 1'b1;
    #1;
    checks++;
    if (alu_out !== 4'b0000) begin
      errors++;
      $display("FAIL sub_eq_out got %b want 0000", alu_out);
    end
    cyc();
    checks++;
    if ({carry_flag, zero_flag} !== 2'b11) begin
      errors++;
      $display("FAIL sub_eq_flags got %b want 11",
               {carry_flag, zero_flag});
    end
    a_data = 4'b0010;
    #1;
    checks++;
    if (alu_out !== 4'b1111) begin
      errors++;
      $display("FAIL sub_borrow_out got %b want 1111", alu_out);
    end
    cyc();
    checks++;
    if ({carry_flag, zero_flag} !== 2'b00) begin
      errors++;
      $display("FAIL sub_borrow_flags got %b want 00",
               {carry_flag, zero_flag});
    end
    Lb = 1'b1;
    ram_data = 4'b0110;
    a_data = 4'b1000;
    #1;
    checks++;
    if (alu_out !== 4'b0101) begin
      errors++;
      $display("FAIL lb_eu_old got %b want 0101", alu_out);
    end
    cyc();
    Lb = 1'b0;
    #1;
    checks++;
    if (alu_out !== 4'b0010) begin
      errors++;
      $display("FAIL lb_eu_new got %b want 0010", alu_out);
    end
    cyc();
    checks++;
    if ({carry_flag, zero_flag} !== 2'b10) begin
      errors++;
      $display("FAIL lb_eu_flags got %b want 10",
               {carry_flag, zero_flag});
    end
    Eu = 1'b0;
    load_b(4'b0000);
    a_data = 4'b0101;
    Eu = 1'b1;
    #1;
    checks++;
    if (alu_out !== 4'b0101) begin
      errors++;
      $display("FAIL sub_b0_out got %b want 0101", alu_out);
    end
    cyc();
    checks++;
    if ({carry_flag, zero_flag} !== 2'b10) begin
      errors++;
      $display("FAIL sub_b0_flags got %b want 10",
               {carry_flag, zero_flag});
    end
    Eu = 1'b0;
    Su = 1'b0;
  endtask

  task automatic test_queue_overflow();
    fifo_cycle(1'b1, 4'b0111, 1'b0);
    fifo_cycle(1'b1, 4'b1001, 1'b0);
    fifo_cycle(1'b1, 4'b1100, 1'b0);
    fifo_cycle(1'b0, 4'b0000, 1'b0);
    fifo_cycle(1'b0, 4'b0000, 1'b1);
    fifo_cycle(1'b0, 4'b0000, 1'b1);
    fifo_cycle(1'b0, 4'b0000, 1'b1);
  endtask

  task automatic test_back_to_back();
    fifo_cycle(1'b1, 4'b0001, 1'b0);
    fifo_cycle(1'b1, 4'b0010, 1'b0);
    fifo_cycle(1'b1, 4'b0011, 1'b1);
    fifo_cycle(1'b1, 4'b0100, 1'b1);
    fifo_cycle(1'b0, 4'b0000, 1'b1);
    fifo_cycle(1'b0, 4'b0000, 1'b1);
    fifo_cycle(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 60; i++) begin
      fifo_cycle(1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) fifo_cycle(1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_reset_mid();
    fifo_cycle(1'b1, 4'b1110, 1'b0);
    fifo_cycle(1'b1, 4'b1101, 1'b0);
    load_b(4'b1010);
    a_data = 4'b0110;
    Eu = 1'b1;
    Su = 1'b0;
    cyc();
    checks++;
    if ({carry_flag, zero_flag} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_flags got %b want 11",
               {carry_flag, zero_flag});
    end
    reset = 1'b1;
    Lo = 1'b1;
    Lb = 1'b1;
    ram_data = 4'b1111;
    cyc();
    exp_q.delete();
    exp_ovf = 1'b0;
    reset = 1'b0;
    Lo = 1'b0;
    Lb = 1'b0;
    Eu = 1'b0;
    checks++;
    if ({out_valid, overflow, carry_flag, zero_flag,
         out_data} !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_state got %h want 00",
               {out_valid, overflow, carry_flag, zero_flag,
                out_data});
    end
    Eu = 1'b1;
    a_data = 4'b0000;
    #1;
    checks++;
    if (alu_out !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_b got %b want 0000", alu_out);
    end
    cyc();
    Eu = 1'b0;
    fifo_cycle(1'b0, 4'd0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    ram_data = '0;
    a_data = '0;
    Lb = 1'b0;
    Su = 1'b0;
    Eu = 1'b0;
    Lo = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_add();
    test_add_wrap();
    test_flag_hold();
    test_sub();
    test_queue_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
